// File: rtl/mem_arbiter_if.sv
// Requester, clear-control and memory-side signals of the unified memory arbiter.
interface mem_arbiter_if #(
   parameter int unsigned IDX_W = 11
);
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              if_err;
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              d_err;
   logic              clr_inst;
   logic              clr_data;
   logic              clr_busy;
   logic              clr_done;
   logic              mem_en;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, clr_inst, clr_data, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
             clr_busy, clr_done, mem_en, mem_we, mem_idx, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, clr_inst, clr_data, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
             clr_busy, clr_done, mem_en, mem_we, mem_idx, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory sequencer: fetch/data arbitration with anti-starvation,
// address decode with error responses, and hardware region clear sweeps.
module mem_arbiter #(
   parameter int unsigned MAX_WAIT   = 4,
   parameter int unsigned MMIO_WORDS = 5,
   parameter int unsigned INST_WORDS = 512,
   parameter int unsigned DATA_WORDS = 1024,
   parameter int unsigned IDX_W      = 11
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   localparam int unsigned WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam int unsigned INST_BASE = MMIO_WORDS;
   localparam int unsigned INST_LAST = MMIO_WORDS + INST_WORDS - 1;
   localparam int unsigned DATA_BASE = INST_LAST + 1;
   localparam int unsigned DATA_LAST = DATA_BASE + DATA_WORDS - 1;
   localparam logic [31:0] MMIO_ADDR = 32'h0010_0000;
   localparam logic [31:0] INST_ADDR = 32'h0100_0000;
   localparam logic [31:0] DATA_ADDR = 32'h8000_0000;
   localparam logic [31:0] MMIO_SPAN = 32'(MMIO_WORDS * 4);
   localparam logic [31:0] INST_SPAN = 32'(INST_WORDS * 4);
   localparam logic [31:0] DATA_SPAN = 32'(DATA_WORDS * 4);

   typedef enum logic [1:0] {SERVE, CLR_INST, CLR_DATA} state_e;
   typedef struct packed {
      logic             err;
      logic [IDX_W-1:0] idx;
   } dec_t;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              inst_pend_q, inst_pend_d, data_pend_q, data_pend_d;
   logic              clr_done_q, clr_done_d;
   logic              d_rvalid_q, d_rvalid_d, d_err_q, d_err_d, d_rd_q, d_rd_d;
   logic              if_rvalid_q, if_rvalid_d, if_err_q, if_err_d, if_rd_q, if_rd_d;
   logic [31:0]       d_hold_q, d_hold_d, if_hold_q, if_hold_d;

   logic              eff_inst, eff_data, sweep_en, d_win, f_win;
   logic              mem_en_c, mem_we_c;
   logic [IDX_W-1:0]  mem_idx_c;
   logic [31:0]       mem_wdata_c, d_rdata_c, if_rdata_c;
   dec_t              f_dec, d_dec;

   // Byte address to word index; fetches may only target the instruction region.
   function automatic dec_t decode(input logic [31:0] a, input logic fetch, input logic we);
      dec_t r;
      r.err = 1'b1;
      r.idx = '0;
      if (a[1:0] == 2'b00) begin
         if ((a - INST_ADDR) < INST_SPAN) begin
            r.err = 1'b0;
            r.idx = IDX_W'((a - INST_ADDR) >> 2) + IDX_W'(INST_BASE);
         end else if (!fetch && ((a - DATA_ADDR) < DATA_SPAN)) begin
            r.err = 1'b0;
            r.idx = IDX_W'((a - DATA_ADDR) >> 2) + IDX_W'(DATA_BASE);
         end else if (!fetch && ((a - MMIO_ADDR) < MMIO_SPAN)) begin
            r.idx = IDX_W'((a - MMIO_ADDR) >> 2);
            r.err = we && (r.idx < IDX_W'(MMIO_WORDS - 1));
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wait_d      = wait_q;
      clr_done_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      d_err_d     = 1'b0;
      d_rd_d      = 1'b0;
      if_rvalid_d = 1'b0;
      if_err_d    = 1'b0;
      if_rd_d     = 1'b0;
      sweep_en    = 1'b0;
      d_win       = 1'b0;
      f_win       = 1'b0;
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_idx_c   = '0;
      mem_wdata_c = 32'h0;
      eff_inst    = inst_pend_q | bus.clr_inst;
      eff_data    = data_pend_q | bus.clr_data;
      f_dec       = decode(bus.if_addr, 1'b1, 1'b0);
      d_dec       = decode(bus.d_addr, 1'b0, bus.d_we);

      case (state_q)
         SERVE: begin
            if (eff_inst) begin
               state_d = CLR_INST;
            end else if (eff_data) begin
               state_d = CLR_DATA;
            end else begin
               d_win = bus.d_req && !(bus.if_req && (wait_q == WAIT_W'(MAX_WAIT)));
               f_win = bus.if_req && !d_win;
            end
         end
         CLR_INST: begin
            sweep_en = 1'b1;
            if (idx_q == IDX_W'(INST_LAST)) begin
               clr_done_d = 1'b1;
               state_d    = eff_data ? CLR_DATA : SERVE;
            end
         end
         CLR_DATA: begin
            sweep_en = 1'b1;
            if (idx_q == IDX_W'(DATA_LAST)) begin
               clr_done_d = 1'b1;
               state_d    = eff_inst ? CLR_INST : SERVE;
            end
         end
         default: state_d = SERVE;
      endcase

      // A pending flag is consumed only when its sweep actually begins.
      inst_pend_d = eff_inst && !((state_d == CLR_INST) && (state_q != CLR_INST));
      data_pend_d = eff_data && !((state_d == CLR_DATA) && (state_q != CLR_DATA));

      if ((state_d == CLR_INST) && (state_q != CLR_INST)) begin
         idx_d = IDX_W'(INST_BASE);
      end else if ((state_d == CLR_DATA) && (state_q != CLR_DATA)) begin
         idx_d = IDX_W'(DATA_BASE);
      end else if (sweep_en) begin
         idx_d = idx_q + IDX_W'(1);
      end

      if (sweep_en) begin
         mem_en_c  = 1'b1;
         mem_we_c  = 1'b1;
         mem_idx_c = idx_q;
      end else if (d_win) begin
         d_rvalid_d  = 1'b1;
         d_err_d     = d_dec.err;
         d_rd_d      = !d_dec.err && !bus.d_we;
         mem_en_c    = !d_dec.err;
         mem_we_c    = !d_dec.err && bus.d_we;
         mem_idx_c   = d_dec.err ? '0 : d_dec.idx;
         mem_wdata_c = (!d_dec.err && bus.d_we) ? bus.d_wdata : 32'h0;
      end else if (f_win) begin
         if_rvalid_d = 1'b1;
         if_err_d    = f_dec.err;
         if_rd_d     = !f_dec.err;
         mem_en_c    = !f_dec.err;
         mem_idx_c   = f_dec.err ? '0 : f_dec.idx;
      end

      if (f_win) begin
         wait_d = '0;
      end else if (bus.if_req && (wait_q < WAIT_W'(MAX_WAIT))) begin
         wait_d = wait_q + WAIT_W'(1);
      end

      // Read data is live on the response cycle, then held until the next response.
      d_rdata_c  = d_rvalid_q ? (d_rd_q ? bus.mem_rdata : 32'h0) : d_hold_q;
      if_rdata_c = if_rvalid_q ? (if_rd_q ? bus.mem_rdata : 32'h0) : if_hold_q;
      d_hold_d   = d_rdata_c;
      if_hold_d  = if_rdata_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SERVE;
         idx_q       <= '0;
         wait_q      <= '0;
         inst_pend_q <= 1'b0;
         data_pend_q <= 1'b0;
         clr_done_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_err_q     <= 1'b0;
         d_rd_q      <= 1'b0;
         d_hold_q    <= 32'h0;
         if_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         if_rd_q     <= 1'b0;
         if_hold_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         inst_pend_q <= inst_pend_d;
         data_pend_q <= data_pend_d;
         clr_done_q  <= clr_done_d;
         d_rvalid_q  <= d_rvalid_d;
         d_err_q     <= d_err_d;
         d_rd_q      <= d_rd_d;
         d_hold_q    <= d_hold_d;
         if_rvalid_q <= if_rvalid_d;
         if_err_q    <= if_err_d;
         if_rd_q     <= if_rd_d;
         if_hold_q   <= if_hold_d;
      end
   end

   // Same-cycle strobes are forced low while reset is asserted.
   assign bus.if_gnt    = f_win & rst_n;
   assign bus.d_gnt     = d_win & rst_n;
   assign bus.mem_en    = mem_en_c & rst_n;
   assign bus.mem_we    = mem_we_c & rst_n;
   assign bus.mem_idx   = rst_n ? mem_idx_c : '0;
   assign bus.mem_wdata = rst_n ? mem_wdata_c : 32'h0;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_err    = if_err_q;
   assign bus.if_rdata  = if_rdata_c;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_err     = d_err_q;
   assign bus.d_rdata   = d_rdata_c;
   assign bus.clr_busy  = (state_q != SERVE);
   assign bus.clr_done  = clr_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and reference model.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.IDX_W(11)) bus();
   mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] phys [2048];
   logic [31:0] ref_mem [2048];
   bit          loaded = 1'b0;
   rsp_t        fq[$], dq[$];
   rsp_t        fe, de;
   int          sweep_q[$];
   bit          done_next;
   int          wait_m;
   bit          f_act, d_act, d_we_v, p_i, p_d;
   logic [31:0] f_addr, d_addr_v, d_wdata_v;
   int          f_gnt_cnt, d_gnt_cnt, done_cnt;
   int          last_idx;
   bit          last_we;

   function automatic logic [31:0] seed_val(input int i);
      return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_5A5A;
   endfunction

   // Behavioural single-port memory: read data appears the cycle after the access.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 2048; i++) phys[i] <= seed_val(i);
         loaded <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we) phys[bus.mem_idx] <= bus.mem_wdata;
         else bus.mem_rdata <= phys[bus.mem_idx];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic int outs_ones();
      return $countones({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err, bus.d_gnt,
                         bus.d_rvalid, bus.d_rdata, bus.d_err, bus.clr_busy, bus.clr_done,
                         bus.mem_en, bus.mem_we, bus.mem_idx, bus.mem_wdata});
   endfunction

   // Address map rules written directly from the region table.
   function automatic void ref_decode(input logic [31:0] a, input bit fetch, input bit we,
                                      output bit ok, output int idx);
      longint ua = longint'(a);
      ok  = 1'b0;
      idx = 0;
      if (ua % 4 != 0) return;
      if (ua >= 64'h0100_0000 && ua <= 64'h0100_07FC) begin
         ok = 1'b1; idx = 5 + int'((ua - 64'h0100_0000) / 4);
      end else if (fetch) begin
         return;
      end else if (ua >= 64'h8000_0000 && ua <= 64'h8000_0FFC) begin
         ok = 1'b1; idx = 517 + int'((ua - 64'h8000_0000) / 4);
      end else if (ua >= 64'h0010_0000 && ua <= 64'h0010_0010) begin
         idx = int'((ua - 64'h0010_0000) / 4);
         ok  = !(we && idx <= 3);
      end
   endfunction

   // Response monitor: every rvalid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.d_rvalid) begin
            if (dq.size() == 0) begin
               checks++; failures++;
               $display("FAIL d_unexpected_rvalid actual=1 required=0");
            end else begin
               de = dq.pop_front();
               chk("d_rsp", 64'({bus.d_err, bus.d_rdata}), 64'(de));
            end
         end
         if (bus.if_rvalid) begin
            if (fq.size() == 0) begin
               checks++; failures++;
               $display("FAIL if_unexpected_rvalid actual=1 required=0");
            end else begin
               fe = fq.pop_front();
               chk("if_rsp", 64'({bus.if_err, bus.if_rdata}), 64'(fe));
            end
         end
      end
   end

   // One clock cycle: drive at posedge+1, evaluate at negedge, return at next posedge+1.
   task automatic step();
      bit ok, ef, ed;
      int idx;
      bus.if_req   = f_act;
      bus.if_addr  = f_addr;
      bus.d_req    = d_act;
      bus.d_we     = d_we_v;
      bus.d_addr   = d_addr_v;
      bus.d_wdata  = d_wdata_v;
      bus.clr_inst = p_i;
      bus.clr_data = p_d;
      @(negedge clk);
      if (bus.if_gnt) f_gnt_cnt++;
      if (bus.d_gnt) d_gnt_cnt++;
      if (bus.clr_done) done_cnt++;
      chk("clr_done", 64'(bus.clr_done), 64'(done_next));
      done_next = 1'b0;
      ef = 1'b0;
      ed = 1'b0;
      if (sweep_q.size() > 0) begin
         idx = sweep_q.pop_front();
         chk("sweep", 64'({bus.clr_busy, bus.mem_en, bus.mem_we, bus.mem_idx, bus.mem_wdata,
                           bus.if_gnt, bus.d_gnt}),
             64'({3'b111, 11'(idx), 32'h0, 2'b00}));
         ref_mem[idx] = 32'h0;
         if (idx == 516 || idx == 1540) done_next = 1'b1;
      end else begin
         chk("busy_idle", 64'(bus.clr_busy), 64'(0));
         if (!(p_i || p_d)) begin
            ed = d_act && !(f_act && wait_m == 4);
            ef = f_act && !ed;
         end
         chk("d_gnt", 64'(bus.d_gnt), 64'(ed));
         chk("if_gnt", 64'(bus.if_gnt), 64'(ef));
         if (!ed && !ef) chk("idle_en", 64'(bus.mem_en), 64'(0));
         if (ed) begin
            ref_decode(d_addr_v, 1'b0, d_we_v, ok, idx);
            last_idx = int'(bus.mem_idx);
            last_we  = bus.mem_we;
            if (ok) begin
               chk("d_mem", 64'({bus.mem_en, bus.mem_we, bus.mem_idx,
                                 (d_we_v ? bus.mem_wdata : 32'h0)}),
                   64'({1'b1, d_we_v, 11'(idx), (d_we_v ? d_wdata_v : 32'h0)}));
               if (d_we_v) begin
                  ref_mem[idx] = d_wdata_v;
                  dq.push_back({1'b0, 32'h0});
               end else begin
                  dq.push_back({1'b0, ref_mem[idx]});
               end
            end else begin
               chk("d_err_en", 64'(bus.mem_en), 64'(0));
               dq.push_back({1'b1, 32'h0});
            end
            d_act = 1'b0;
         end
         if (ef) begin
            ref_decode(f_addr, 1'b1, 1'b0, ok, idx);
            if (ok) begin
               chk("if_mem", 64'({bus.mem_en, bus.mem_we, bus.mem_idx}),
                   64'({2'b10, 11'(idx)}));
               fq.push_back({1'b0, ref_mem[idx]});
            end else begin
               chk("if_err_en", 64'(bus.mem_en), 64'(0));
               fq.push_back({1'b1, 32'h0});
            end
            f_act = 1'b0;
         end
      end
      if (ef) wait_m = 0;
      else if (bus.if_req && wait_m < 4) wait_m++;
      if (p_i) for (int i = 5; i <= 516; i++) sweep_q.push_back(i);
      if (p_d) for (int i = 517; i <= 1540; i++) sweep_q.push_back(i);
      p_i = 1'b0;
      p_d = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_idle(input int bound);
      int n = 0;
      while ((f_act || d_act) && n < bound) begin
         step();
         n++;
      end
      chk("req_timeout", 64'(f_act | d_act), 64'(0));
   endtask

   task automatic data_op(input bit we, input logic [31:0] a, input logic [31:0] wd);
      d_act = 1'b1; d_we_v = we; d_addr_v = a; d_wdata_v = wd;
      run_idle(20);
   endtask

   task automatic fetch_op(input logic [31:0] a);
      f_act = 1'b1; f_addr = a;
      run_idle(20);
   endtask

   function automatic logic [31:0] rand_addr(input bit fetch);
      int c = $urandom_range(0, 9);
      if (fetch && $urandom_range(0, 3) != 0) c = 3;
      case (c)
         0, 1, 2: return 32'h8000_0000 + 32'(4 * $urandom_range(0, 1023));
         3, 4:    return 32'h0100_0000 + 32'(4 * $urandom_range(0, 511));
         5:       return 32'h0010_0000 + 32'(4 * $urandom_range(0, 4));
         6:       return 32'h8000_0000 + 32'(4 * $urandom_range(0, 1023) + $urandom_range(1, 3));
         7: begin
            case ($urandom_range(0, 5))
               0: return 32'h000F_FFFC;
               1: return 32'h0010_0014;
               2: return 32'h0100_0800;
               3: return 32'h00FF_FFFC;
               4: return 32'h8000_1000;
               default: return 32'h7FFF_FFFC;
            endcase
         end
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int fc, dc, g;
      for (int i = 0; i < 2048; i++) ref_mem[i] = seed_val(i);
      {f_act, d_act, d_we_v, p_i, p_d, done_next} = '0;
      f_addr = 32'h0; d_addr_v = 32'h0; d_wdata_v = 32'h0;
      wait_m = 0; f_gnt_cnt = 0; d_gnt_cnt = 0; done_cnt = 0;
      bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.clr_inst = 1'b0; bus.clr_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 64'(outs_ones()), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      data_op(1'b1, 32'h8000_0004, 32'hDEAD_BEEF);
      chk("wr_idx", 64'(last_idx), 64'(518));
      chk("wr_we", 64'(last_we), 64'(1));
      data_op(1'b0, 32'h8000_0004, 32'h0);
      repeat (2) step();

      fc = f_gnt_cnt; dc = d_gnt_cnt;
      for (int c = 0; c < 10; c++) begin
         if (!f_act) begin f_act = 1'b1; f_addr = 32'h0100_0000 + 32'(4 * $urandom_range(0, 511)); end
         if (!d_act) begin
            d_act = 1'b1; d_we_v = 1'b0;
            d_addr_v = 32'h8000_0000 + 32'(4 * $urandom_range(0, 1023));
         end
         step();
      end
      chk("arb_fetch_grants", 64'(f_gnt_cnt - fc), 64'(2));
      chk("arb_data_grants", 64'(d_gnt_cnt - dc), 64'(8));
      run_idle(20);

      fetch_op(32'h0100_0002);
      fetch_op(32'h8000_0000);
      data_op(1'b1, 32'h0010_0004, 32'h1111_2222);
      data_op(1'b1, 32'h0010_0010, 32'h1234_5678);
      chk("mmio4_idx", 64'(last_idx), 64'(4));
      data_op(1'b0, 32'h0010_0010, 32'h0);
      repeat (2) step();

      fc = f_gnt_cnt; dc = done_cnt;
      f_act = 1'b1; f_addr = 32'h0100_0010;
      p_i = 1'b1; p_d = 1'b1;
      repeat (1537) step();
      chk("clr_no_fetch", 64'(f_gnt_cnt - fc), 64'(0));
      step();
      chk("clr_fetch_after", 64'(f_gnt_cnt - fc), 64'(1));
      chk("clr_done_count", 64'(done_cnt - dc), 64'(2));
      repeat (2) step();

      data_op(1'b1, 32'h8000_0000 + 32'(4 * 100), 32'hA5A5_0F0F);
      data_op(1'b1, 32'h8000_0000 + 32'(4 * 600), 32'hC3C3_7E7E);
      repeat (2) step();
      p_d = 1'b1;
      repeat (301) step();
      rst_n = 1'b0;
      #1;
      chk("abort_outs", 64'(outs_ones()), 64'(0));
      repeat (2) begin
         @(negedge clk);
         chk("abort_quiet", 64'(outs_ones()), 64'(0));
      end
      rst_n = 1'b1;
      sweep_q.delete();
      done_next = 1'b0;
      wait_m = 0;
      @(posedge clk);
      #1;
      g = d_gnt_cnt;
      d_act = 1'b1; d_we_v = 1'b0; d_addr_v = 32'h8000_0000 + 32'(4 * 100);
      step();
      chk("post_reset_first_gnt", 64'(d_gnt_cnt - g), 64'(1));
      data_op(1'b0, 32'h8000_0000 + 32'(4 * 600), 32'h0);
      repeat (2) step();

      for (int c = 0; c < 1500; c++) begin
         if (!f_act && $urandom_range(0, 2) == 0) begin f_act = 1'b1; f_addr = rand_addr(1'b1); end
         if (!d_act && $urandom_range(0, 1) == 0) begin
            d_act = 1'b1; d_we_v = 1'($urandom_range(0, 1));
            d_addr_v = rand_addr(1'b0); d_wdata_v = $urandom;
         end
         step();
      end
      run_idle(20);
      repeat (4) step();
      chk("d_outstanding", 64'(dq.size()), 64'(0));
      chk("if_outstanding", 64'(fq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences all accesses to the unified 1541-word single-port memory array (MMIO, instruction and data regions).
- Arbitrates between the instruction-fetch requester and the load/store requester.
- Decodes byte addresses to word indices and flags illegal accesses.
- Runs hardware clear sweeps of the instruction and data regions, one word per cycle.

Parameters:
- MAX_WAIT, 4, consecutive cycles a pending fetch may lose before it is forced to win.
- MMIO_WORDS, 5, MMIO words at 0x00100000..0x00100010, index 0..4.
- INST_WORDS, 512, instruction words at 0x01000000..0x010007FC, index 5..516.
- DATA_WORDS, 1024, data words at 0x80000000..0x80000FFC, index 517..1540.
- IDX_W, 11, memory word-index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetch data.
- if_err  out  1  fetch error, qualified by if_rvalid.
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  1 = write.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response valid; pulses for both reads and writes.
- d_rdata  out  32  read data.
- d_err  out  1  data error, qualified by d_rvalid.
- clr_inst  in  1  single-cycle pulse: zero the instruction region.
- clr_data  in  1  single-cycle pulse: zero the data region.
- clr_busy  out  1  a sweep is in progress.
- clr_done  out  1  one-cycle pulse after the final word of a sweep is written.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_idx  out  IDX_W  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read with mem_en=1.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is SERVE.
  - Wait counter and pending-clear flags are 0.
- States:
  - SERVE, CLR_INST, CLR_DATA.
  - SERVE→CLR_INST when the inst-clear pending flag is set.
  - Otherwise SERVE→CLR_DATA when the data-clear pending flag is set.
  - The clear check is made every SERVE cycle, before any grant.
  - A sweep returns to SERVE, or goes directly to the other sweep if its flag is pending.
- Clear pending flags:
  - A clr_inst or clr_data pulse sets its flag.
  - The flag clears when its sweep starts.
  - A pulse arriving during its own sweep re-arms the flag, so the sweep repeats.
  - Both flags set together: inst sweep runs first.
- Sweep:
  - mem_en=1, mem_we=1, mem_wdata=0.
  - mem_idx steps from the region base to the region end, one word per cycle: 512 or 1024 cycles.
  - clr_busy=1 for the whole sweep.
  - clr_done pulses the cycle after the last write.
  - No grants are given during a sweep; requesters keep their req held.
- Arbitration in SERVE: at most one grant per cycle.
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both: data wins unless the wait count equals MAX_WAIT, in which case fetch wins.
  - Wait count increments each cycle if_req is high without if_gnt, including sweep cycles, saturating at MAX_WAIT.
  - Wait count resets to 0 on if_gnt.
- Decode on the grant cycle:
  - Index = region base index + (addr − region base)>>2.
  - Error cases:
    - addr[1:0]≠0.
    - Address outside all regions.
    - Fetch from a non-instruction region.
    - Data write to MMIO index 0..3 (read-only).
    - MMIO index 4 at 0x00100010 is read/write.
  - Data port may read and write the instruction region.
- Error response:
  - Error grants drive mem_en=0.
  - Response one cycle after the grant: rvalid=1, err=1, rdata=0.
- Normal response:
  - Grant drives mem_en=1, mem_we=d_we, mem_idx and mem_wdata.
  - rvalid pulses exactly 1 cycle later.
  - Reads: rdata=mem_rdata. Writes: rdata=0.
  - rdata holds its value until the next rvalid.
- Back-to-back grants are legal, one per cycle; responses return in grant order.
- Reset mid-sweep or mid-response:
  - Everything aborts immediately.
  - No clr_done, no rvalid.
  - Partially cleared words stay cleared.

Test Plan:
- Reset, then d_req write of 0xDEADBEEF to 0x80000004, then read back → write grant with mem_idx=518, mem_we=1; d_rvalid next cycle, d_err=0. Read returns d_rdata=0xDEADBEEF.
- if_req and d_req held high together for 10 cycles → data wins 4 grants, fetch gets the 5th, and the pattern repeats (MAX_WAIT=4). Fetch is never starved.
- Fetch 0x01000002, then fetch 0x80000000, then data write to 0x00100004 → each gets a grant with mem_en=0, then rvalid=1, err=1, rdata=0.
- Data write 0x12345678 to 0x00100010 → mem_idx=4, no error; readback returns 0x12345678.
- clr_inst and clr_data pulsed in the same cycle with if_req held → clr_busy for 1536 cycles, mem_idx 5..516 then 517..1540, all writes 0. Two clr_done pulses. if_gnt only after the second sweep.
- rst_n asserted low at word 300 of a data sweep → outputs 0 at once, no clr_done. After release, state is SERVE and the next request is granted in its first cycle.
